// File: rtl/fma_pack.sv
// FMA back end: normalise, round-to-nearest-even and pack a Q4.46 result into binary32.
// Optional status flags (overflow/underflow/inexact) are enabled by defining FMA_PACK_FLAGS_EN.
module fma_pack #(
  parameter int EXP_W   = 10,
  parameter int MANT_W  = 50,
  parameter int FRAC_PT = 46
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] m_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       data_out
`ifdef FMA_PACK_FLAGS_EN
  ,
  output logic              flag_overflow,
  output logic              flag_underflow,
  output logic              flag_inexact
`endif
);

  localparam int PW = $clog2(MANT_W);
  localparam int EW = EXP_W + 2;
  localparam int GB = MANT_W - 25;

  logic              w_en;
  logic [PW-1:0]     w_p;
  logic [MANT_W-1:0] w_norm;
  logic [EW-1:0]     w_e1;

  logic              r_v1, r_sign1, r_zero1, r_g1, r_s1;
  logic [EW-1:0]     r_e1;
  logic [22:0]       r_frac1;

  logic              w_up, w_c;
  logic [22:0]       w_frac2;
  logic [EW-1:0]     w_e2;

  logic              r_v2, r_sign2, r_zero2;
  logic [EW-1:0]     r_e2;
  logic [22:0]       r_frac2;

  logic              w_ovf, w_unf;
  logic [31:0]       w_pack;
  logic              r_v3;
  logic [31:0]       r_data;

  assign w_en      = !r_v3 | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign data_out  = r_data;

  // Stage 1: leading-one position, then shift so the hidden bit lands in the MSB.
  always_comb begin
    w_p = '0;
    for (int i = 0; i < MANT_W; i++)
      if (m_in[i]) w_p = PW'(i);
  end

  assign w_norm = m_in << (PW'(MANT_W - 1) - w_p);
  assign w_e1   = {{2{exp_in[EXP_W-1]}}, exp_in} + EW'(w_p) - EW'(FRAC_PT);

  // Stage 2: RNE increment; a carry out of the fraction bumps the exponent.
  assign w_up            = r_g1 & (r_s1 | r_frac1[0]);
  assign {w_c, w_frac2}  = {1'b0, r_frac1} + {23'b0, w_up};
  assign w_e2            = r_e1 + EW'(w_c);

  // Stage 3: zero wins over range checks; no subnormals are produced.
  assign w_ovf = !r_zero2 && ($signed(r_e2) >= $signed(EW'(255)));
  assign w_unf = !r_zero2 && !w_ovf && ($signed(r_e2) <= $signed(EW'(0)));

  always_comb begin
    w_pack = {r_sign2, 31'b0};
    if (w_ovf)
      w_pack = {r_sign2, 8'hFF, 23'b0};
    else if (!r_zero2 && !w_unf)
      w_pack = {r_sign2, r_e2[7:0], r_frac2};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_sign1 <= 1'b0;
      r_zero1 <= 1'b0;
      r_g1    <= 1'b0;
      r_s1    <= 1'b0;
      r_e1    <= '0;
      r_frac1 <= '0;
      r_v2    <= 1'b0;
      r_sign2 <= 1'b0;
      r_zero2 <= 1'b0;
      r_e2    <= '0;
      r_frac2 <= '0;
      r_v3    <= 1'b0;
      r_data  <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_sign1 <= sign_in;
      r_zero1 <= (m_in == '0);
      r_e1    <= w_e1;
      r_frac1 <= w_norm[MANT_W-2 -: 23];
      r_g1    <= w_norm[GB];
      r_s1    <= |w_norm[GB-1:0];
      r_v2    <= r_v1;
      r_sign2 <= r_sign1;
      r_zero2 <= r_zero1;
      r_e2    <= w_e2;
      r_frac2 <= w_frac2;
      r_v3    <= r_v2;
      if (r_v2) r_data <= w_pack;
    end
  end

`ifdef FMA_PACK_FLAGS_EN
  logic r_inx2, r_fo, r_fu, r_fi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inx2 <= 1'b0;
      r_fo   <= 1'b0;
      r_fu   <= 1'b0;
      r_fi   <= 1'b0;
    end else if (w_en) begin
      r_inx2 <= r_g1 | r_s1;
      if (r_v2) begin
        r_fo <= w_ovf;
        r_fu <= w_unf;
        r_fi <= r_inx2 | w_ovf | w_unf;
      end
    end
  end

  assign flag_overflow  = r_fo & r_v3;
  assign flag_underflow = r_fu & r_v3;
  assign flag_inexact   = r_fi & r_v3;
`endif

endmodule

// File: tb/tb_fma_pack.sv
// Directed bench for fma_pack: single-beat vectors with latency checks, backpressure, reset mid-stream.
module tb_fma_pack;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sign_in = 1'b0;
  logic        out_ready = 1'b1;
  logic [9:0]  exp_in = '0;
  logic [49:0] m_in = '0;
  wire         in_ready, out_valid;
  wire [31:0]  data_out;
`ifdef FMA_PACK_FLAGS_EN
  wire         flag_overflow, flag_underflow, flag_inexact;
`endif

  int checks = 0;
  int errors = 0;

  fma_pack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .m_in(m_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
`ifdef FMA_PACK_FLAGS_EN
    , .flag_overflow(flag_overflow), .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic run_one(input string tag, input logic s, input logic [9:0] e,
                         input logic [49:0] m, input logic [31:0] exp_word);
    int n;
    n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sign_in   = s;
    exp_in    = e;
    m_in      = m;
    do begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
    end while (!out_valid && n < 10);
    chk({tag, "_lat"}, n, 3);
    chk(tag, data_out, exp_word);
  endtask

  logic [31:0] bp_exp [6];
  logic [49:0] ones_46_22;
  int idx, nout;
  bit acc;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    run_one("one",      1'b0, 10'd127, 50'd1 << 46, 32'h3F80_0000);
    run_one("norm_up",  1'b0, 10'd127, 50'd1 << 47, 32'h4000_0000);
    run_one("norm_dn",  1'b0, 10'd127, 50'd1 << 45, 32'h3F00_0000);
    run_one("msb49",    1'b0, 10'd127, 50'd1 << 49, 32'h4100_0000);
    run_one("lsb0",     1'b0, 10'd127, 50'd1,       32'h2880_0000);
    run_one("rne_tie",  1'b0, 10'd127, (50'd1 << 46) | (50'd1 << 22), 32'h3F80_0000);
    run_one("rne_up",   1'b0, 10'd127, (50'd1 << 46) | (50'd1 << 23) | (50'd1 << 22), 32'h3F80_0002);
    ones_46_22 = {3'b0, 25'h1FF_FFFF, 22'b0};
    run_one("rne_carry", 1'b0, 10'd127, ones_46_22, 32'h4000_0000);
    run_one("ovf",      1'b0, 10'd255, 50'd1 << 46, 32'h7F80_0000);
    run_one("max_norm", 1'b0, 10'd254, 50'd1 << 46, 32'h7F00_0000);
    run_one("carry_ovf", 1'b1, 10'd254, ones_46_22, 32'hFF80_0000);
    run_one("unf",      1'b1, 10'd0,   50'd1 << 46, 32'h8000_0000);
    run_one("min_norm", 1'b0, 10'd1,   50'd1 << 46, 32'h0080_0000);
    run_one("neg_exp",  1'b0, 10'h3F6, 50'd1 << 46, 32'h0000_0000);
    run_one("zero",     1'b1, 10'd127, 50'd0,       32'h8000_0000);

    // Backpressure: 6 back-to-back beats, out_ready low for the first 5 cycles.
    for (int k = 0; k < 6; k++)
      bp_exp[k] = (32'(127 + k) << 23) | (32'(k) << 17);
    idx = 0;
    nout = 0;
    acc = 1'b0;
    for (int c = 0; c < 60 && nout < 6; c++) begin
      @(negedge clk);
      if (acc) idx++;
      out_ready = (c >= 5);
      in_valid  = (idx < 6);
      sign_in   = 1'b0;
      exp_in    = 10'(127 + idx);
      m_in      = (50'd1 << 46) | (50'(idx) << 40);
      #1;
      acc = in_valid & in_ready;
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      if (out_valid) chk($sformatf("bp_data%0d", nout), data_out, bp_exp[nout]);
      if (out_valid && out_ready) nout++;
    end
    in_valid = 1'b0;
    chk("bp_count", nout, 6);
    repeat (4) begin
      @(negedge clk);
      chk("bp_nodup", out_valid, 0);
    end

    // Reset with three beats in flight.
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      exp_in   = 10'(100 + k);
      m_in     = 50'd1 << 46;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_data", data_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    chk("post_rst_ready", in_ready, 1);
    run_one("post_rst", 1'b0, 10'd127, 50'd1 << 46, 32'h3F80_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
